insn_fetch: RTL

Instruction fetch sequencer that drives the instruction decoder. It reads 32-bit instruction words from a word-addressed instruction memory over a request/acknowledge handshake. It presents each word to the decoder with a one-cycle decode strobe, then samples the decoder's verdict. It stops on a decoded halt or an invalid instruction, and sits between instruction memory and the decoder at the front of the core.

---
 rtl/insn_fetch_if.sv | 27 ++
 rtl/insn_fetch.sv | 107 ++++++++++
 2 files changed

// File: rtl/insn_fetch_if.sv
// insn_fetch_if: bundles the instruction-memory read handshake and the
// decoder strobe/verdict signals used by insn_fetch.
//   master (fetch unit): drives o_mem_req, o_mem_addr, o_insn, o_decode;
//                        receives i_mem_ack, i_mem_data, i_valid, i_halt.
//   slave  (memory + decoder side): the mirror image.
interface insn_fetch_if #(
    parameter int ADDR_W = 16
);
    logic              o_mem_req;
    logic [ADDR_W-1:0] o_mem_addr;
    logic              i_mem_ack;
    logic [31:0]       i_mem_data;
    logic [31:0]       o_insn;
    logic              o_decode;
    logic              i_valid;
    logic              i_halt;

    modport master (
        output o_mem_req, o_mem_addr, o_insn, o_decode,
        input  i_mem_ack, i_mem_data, i_valid, i_halt
    );

    modport slave (
        input  o_mem_req, o_mem_addr, o_insn, o_decode,
        output i_mem_ack, i_mem_data, i_valid, i_halt
    );
endinterface

// File: rtl/insn_fetch.sv
// insn_fetch: instruction fetch sequencer in front of the decoder.
// Reads one word per instruction over a req/ack handshake, strobes it into
// the decoder for one cycle, then acts on the decoder's valid/halt verdict.
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start, i_start_pc start pulse and first address (IDLE/HALTED/FAULT only)
//   bus                 memory handshake + decoder interface (master side)
//   o_pc                address of the current instruction
//   o_busy              FETCH/ISSUE/CHECK
//   o_halted, o_fault   stopped on a halt / on an invalid instruction
//   o_count             valid instructions retired since the last start
module insn_fetch #(
    parameter int                ADDR_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [ADDR_W-1:0] i_start_pc,
    insn_fetch_if.master      bus,
    output logic [ADDR_W-1:0] o_pc,
    output logic              o_busy,
    output logic              o_halted,
    output logic              o_fault,
    output logic [31:0]       o_count
);
    typedef enum logic [2:0] {
        IDLE, FETCH, ISSUE, CHECK, HALTED, FAULT
    } state_t;

    state_t      state;
    logic        mem_req;
    logic        decode;
    logic [31:0] insn;

    // The memory address is the PC itself, so it cannot move during a request.
    assign bus.o_mem_req  = mem_req;
    assign bus.o_mem_addr = o_pc;
    assign bus.o_insn     = insn;
    assign bus.o_decode   = decode;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            o_pc     <= RESET_PC;
            mem_req  <= 1'b0;
            insn     <= '0;
            decode   <= 1'b0;
            o_count  <= '0;
            o_busy   <= 1'b0;
            o_halted <= 1'b0;
            o_fault  <= 1'b0;
        end else begin
            // The strobe is only ever set on the FETCH->ISSUE edge, so this
            // default makes it exactly one cycle wide.
            decode <= 1'b0;
            case (state)
                IDLE, HALTED, FAULT: begin
                    if (i_start) begin
                        o_pc     <= i_start_pc;
                        o_count  <= '0;
                        mem_req  <= 1'b1;
                        o_busy   <= 1'b1;
                        o_halted <= 1'b0;
                        o_fault  <= 1'b0;
                        state    <= FETCH;
                    end
                end
                FETCH: begin
                    if (bus.i_mem_ack) begin
                        insn    <= bus.i_mem_data;
                        mem_req <= 1'b0;
                        decode  <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    // Decoder registers its verdict on this edge.
                    state <= CHECK;
                end
                CHECK: begin
                    if (!bus.i_valid) begin
                        o_busy  <= 1'b0;
                        o_fault <= 1'b1;
                        state   <= FAULT;
                    end else if (bus.i_halt) begin
                        o_count  <= o_count + 32'd1;
                        o_busy   <= 1'b0;
                        o_halted <= 1'b1;
                        state    <= HALTED;
                    end else begin
                        // PC wraps silently at 2^ADDR_W.
                        o_count <= o_count + 32'd1;
                        o_pc    <= o_pc + ADDR_W'(1);
                        mem_req <= 1'b1;
                        state   <= FETCH;
                    end
                end
                default: begin
                    mem_req <= 1'b0;
                    o_busy  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end
endmodule
